// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel edge detector. Each channel takes an asynchronous pin level
// through a synchroniser and a glitch filter, then produces one-cycle rising,
// falling and any-edge pulses. A per-channel mode mask selects which edges are
// reported as events. Events set a sticky flag and bump a saturating counter,
// both cleared by a write-1 clear. irq is the OR of all sticky flags.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   sig_in        [CHANNELS]           asynchronous input levels
//   mode          [2*CHANNELS]         per channel: 00 off, 01 rise, 10 fall, 11 any
//   clear         [CHANNELS]           write-1 clear of sticky flag and counter
//   rising_edge   [CHANNELS]           accepted 0->1 pulse (unmasked)
//   falling_edge  [CHANNELS]           accepted 1->0 pulse (unmasked)
//   any_edge      [CHANNELS]           rising_edge | falling_edge
//   event_pulse   [CHANNELS]           edge pulse qualified by mode
//   event_sticky  [CHANNELS]           latched event_pulse until cleared
//   edge_count    [CHANNELS*CNT_WIDTH] saturating event counters
//   irq                                OR of all event_sticky bits
// -----------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           sig_in,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]           clear,
    output logic [CHANNELS-1:0]           rising_edge,
    output logic [CHANNELS-1:0]           falling_edge,
    output logic [CHANNELS-1:0]           any_edge,
    output logic [CHANNELS-1:0]           event_pulse,
    output logic [CHANNELS-1:0]           event_sticky,
    output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
    output logic                          irq
);

    localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FCW-1:0]       FC_MAX  = FCW'(FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r     [CHANNELS];
    logic [FCW-1:0]         fcnt_r     [CHANNELS];
    logic [FCW-1:0]         fcnt_next_s[CHANNELS];
    logic [CNT_WIDTH-1:0]   cnt_r      [CHANNELS];
    logic [CNT_WIDTH-1:0]   cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0]    filt_r;       // filtered (accepted) level
    logic [CHANNELS-1:0]    filt_next_s;
    logic [CHANNELS-1:0]    lvl_r;        // filtered level one cycle later, reference for the edge compare
    logic [CHANNELS-1:0]    sticky_next_s;

    // Filter decision, mode qualification, sticky/counter next-state, counter packing.
    always_comb begin
        filt_next_s   = filt_r;
        sticky_next_s = event_sticky;
        event_pulse   = {CHANNELS{1'b0}};
        edge_count    = {(CHANNELS*CNT_WIDTH){1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            fcnt_next_s[i] = fcnt_r[i];
            cnt_next_s[i]  = cnt_r[i];

            // A deviation must persist FILTER_CYCLES consecutive cycles to flip the level.
            if (sync_r[i][SYNC_STAGES-1] == filt_r[i]) begin
                fcnt_next_s[i] = {FCW{1'b0}};
            end else if (fcnt_r[i] == FC_MAX) begin
                filt_next_s[i] = ~filt_r[i];
                fcnt_next_s[i] = {FCW{1'b0}};
            end else begin
                fcnt_next_s[i] = fcnt_r[i] + FCW'(1);
            end

            event_pulse[i] = (rising_edge[i] & mode[2*i]) | (falling_edge[i] & mode[2*i+1]);

            // Set wins over clear; a clear coinciding with an event leaves a count of one.
            sticky_next_s[i] = event_pulse[i] | (event_sticky[i] & ~clear[i]);
            if (clear[i]) begin
                cnt_next_s[i] = event_pulse[i] ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
            end else if (event_pulse[i] && (cnt_r[i] != CNT_MAX)) begin
                cnt_next_s[i] = cnt_r[i] + CNT_WIDTH'(1);
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end

            edge_count[CNT_WIDTH*i +: CNT_WIDTH] = cnt_r[i];
        end
    end

    // All channel state: synchronisers, filters, edge pulses, sticky flags, counters, irq.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i] <= {SYNC_STAGES{1'b0}};
                fcnt_r[i] <= {FCW{1'b0}};
                cnt_r[i]  <= {CNT_WIDTH{1'b0}};
            end
            filt_r       <= {CHANNELS{1'b0}};
            lvl_r        <= {CHANNELS{1'b0}};
            rising_edge  <= {CHANNELS{1'b0}};
            falling_edge <= {CHANNELS{1'b0}};
            any_edge     <= {CHANNELS{1'b0}};
            event_sticky <= {CHANNELS{1'b0}};
            irq          <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], sig_in[i]};
                fcnt_r[i] <= fcnt_next_s[i];
                cnt_r[i]  <= cnt_next_s[i];
            end
            filt_r       <= filt_next_s;
            lvl_r        <= filt_r;
            rising_edge  <= filt_r & ~lvl_r;
            falling_edge <= ~filt_r & lvl_r;
            any_edge     <= filt_r ^ lvl_r;
            event_sticky <= sticky_next_s;
            irq          <= |sticky_next_s;
        end
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 4;
    localparam int CW = 2;
    localparam int LAT = SS + FC + 1;   // step index (t0 = step 1) at which the pulse is seen

    logic              clock = 1'b0;
    logic              reset;
    logic [CH-1:0]     sig_in;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     clear;
    logic [CH-1:0]     rising_edge, falling_edge, any_edge, event_pulse, event_sticky;
    logic [CH*CW-1:0]  edge_count;
    logic              irq;

    int checks = 0;
    int errors = 0;

    edge_detect_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .sig_in(sig_in), .mode(mode), .clear(clear),
        .rising_edge(rising_edge), .falling_edge(falling_edge), .any_edge(any_edge),
        .event_pulse(event_pulse), .event_sticky(event_sticky), .edge_count(edge_count),
        .irq(irq)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // The accepted level flips when the last FC synchronised samples all
    // differ from it; the synchronised sample at edge k is sig_in sampled SS edges earlier.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_filt, m_rise, m_fall, m_tup, m_tdn, m_sticky;
    int            m_cnt[CH];
    logic          m_irq;

    int step_idx;
    int first_rise[CH];
    int rise_seen[CH], fall_seen[CH], ev_seen[CH];

    function automatic logic [CH-1:0] hist_at(int back);
        if (back < hist.size()) return hist[hist.size()-1-back];
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_filt = '0; m_rise = '0; m_fall = '0; m_tup = '0; m_tdn = '0; m_sticky = '0; m_irq = 1'b0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] ev;
        for (int c = 0; c < CH; c++) begin
            ev[c] = (m_rise[c] & mode[2*c]) | (m_fall[c] & mode[2*c+1]);
            if (clear[c]) begin
                m_sticky[c] = ev[c];
                m_cnt[c] = ev[c] ? 1 : 0;
            end else if (ev[c]) begin
                m_sticky[c] = 1'b1;
                m_cnt[c] = (m_cnt[c] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt[c] + 1;
            end
        end
        m_irq  = |m_sticky;
        m_rise = m_tup;
        m_fall = m_tdn;
        hist.push_back(sig_in);
        if (hist.size() > 32) void'(hist.pop_front());
        for (int c = 0; c < CH; c++) begin
            bit stable = 1'b1;
            for (int j = 0; j < FC; j++)
                if (hist_at(SS + j)[c] == m_filt[c]) stable = 1'b0;
            m_tup[c] = stable & ~m_filt[c];
            m_tdn[c] = stable & m_filt[c];
            if (stable) m_filt[c] = ~m_filt[c];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CH-1:0]    exp_ev;
        logic [CH*CW-1:0] exp_cnt;
        for (int c = 0; c < CH; c++) begin
            exp_ev[c] = (m_rise[c] & mode[2*c]) | (m_fall[c] & mode[2*c+1]);
            exp_cnt[CW*c +: CW] = m_cnt[c][CW-1:0];
        end
        chk("rising_edge",  32'(rising_edge),  32'(m_rise));
        chk("falling_edge", 32'(falling_edge), 32'(m_fall));
        chk("any_edge",     32'(any_edge),     32'(m_rise | m_fall));
        chk("event_pulse",  32'(event_pulse),  32'(exp_ev));
        chk("event_sticky", 32'(event_sticky), 32'(m_sticky));
        chk("edge_count",   32'(edge_count),   32'(exp_cnt));
        chk("irq",          32'(irq),          32'(m_irq));
    endtask

    task automatic mark();
        step_idx = 0;
        for (int c = 0; c < CH; c++) begin
            first_rise[c] = 0; rise_seen[c] = 0; fall_seen[c] = 0; ev_seen[c] = 0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_edge();
        @(negedge clock);
        step_idx++;
        check_all();
        for (int c = 0; c < CH; c++) begin
            if (rising_edge[c] && first_rise[c] == 0) first_rise[c] = step_idx;
            rise_seen[c] += int'(rising_edge[c]);
            fall_seen[c] += int'(falling_edge[c]);
            ev_seen[c]   += int'(event_pulse[c]);
        end
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic async_reset(string tag);
        #2 reset = 1'b0;
        #1;
        chk(tag, {rising_edge, falling_edge, any_edge, event_pulse, event_sticky, edge_count, irq}, 32'd0);
        model_reset();
    endtask

    initial begin
        logic found;
        reset = 1'b0; sig_in = '0; mode = '0; clear = '0;
        model_reset();
        mark();
        run(3);
        reset = 1'b1;

        // Single edge on channel 0, latency and bookkeeping
        mode = {2'b11, 2'b01, 2'b11, 2'b11};
        run(4);
        mark();
        sig_in[0] = 1'b1;
        run(20);
        chk("lat_ch0",     first_rise[0], LAT);
        chk("rise_cnt0",   rise_seen[0], 1);
        chk("ev_cnt0",     ev_seen[0], 1);
        chk("sticky0",     32'(event_sticky[0]), 1);
        chk("count0",      32'(edge_count[CW-1:0]), 1);
        chk("irq_single",  32'(irq), 1);

        // Glitch of 3 cycles on channel 1 is rejected, then a long pulse is accepted
        mark();
        sig_in[1] = 1'b1; run(3);
        sig_in[1] = 1'b0; run(12);
        chk("glitch_none", rise_seen[1], 0);
        sig_in[1] = 1'b1; run(12);
        chk("glitch_then", rise_seen[1], 1);

        // Mode masking on channel 2 (rising only)
        mark();
        sig_in[2] = 1'b1; run(12);
        sig_in[2] = 1'b0; run(12);
        chk("mask_rise", rise_seen[2], 1);
        chk("mask_fall", fall_seen[2], 1);
        chk("mask_ev",   ev_seen[2], 1);
        chk("mask_cnt",  32'(edge_count[2*CW +: CW]), 1);

        // Saturation on channel 3, then clear colliding with an event
        for (int k = 0; k < 5; k++) begin
            sig_in[3] = ~sig_in[3]; run(10);
        end
        chk("sat_cnt3", 32'(edge_count[3*CW +: CW]), 3);
        sig_in[3] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = event_pulse[3];
        end
        chk("ev_wait3", 32'(found), 1);
        clear[3] = 1'b1; step(); clear[3] = 1'b0;
        chk("clr_set_cnt",    32'(edge_count[3*CW +: CW]), 1);
        chk("clr_set_sticky", 32'(event_sticky[3]), 1);
        clear = '1; step(); clear = '0;
        chk("clr_irq", 32'(irq), 0);
        chk("clr_cnt", 32'(edge_count), 0);

        // Inputs high across reset release: one rising edge per channel after full latency
        sig_in = '1;
        async_reset("rst_async1");
        run(3);
        reset = 1'b1;
        mark();
        run(15);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rel_lat%0d", c), first_rise[c], LAT);
            chk($sformatf("rel_cnt%0d", c), rise_seen[c], 1);
        end

        // Reset in the middle of filtering discards progress
        sig_in = '0; run(15);
        sig_in = '1; run(4);
        async_reset("rst_async2");
        run(2);
        reset = 1'b1;
        mark();
        run(15);
        chk("midrst_lat", first_rise[0], LAT);
        chk("midrst_cnt", rise_seen[3], 1);

        // All channels toggle together
        mode = '1;
        clear = '1; step(); clear = '0;
        sig_in = '0; run(12);
        sig_in = '1; run(12);
        chk("simul_cnt", 32'(edge_count), {CH{CW'(2)}});

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(5) == 0) sig_in[c] = ~sig_in[c];
            if ($urandom_range(40) == 0) mode = 8'($urandom);
            clear = ($urandom_range(15) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(400) == 0) begin
                async_reset("rst_rand");
                step();
                reset = 1'b1;
            end
            step();
        end
        clear = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
